// File: rtl/mult_pkg.sv
// Shared types and elaboration-time helpers for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of compute cycles: one per DIGIT-bit slice of the multiplier.
  function automatic int unsigned iter_count(input int unsigned width,
                                             input int unsigned digit);
    return (digit == 0) ? 1 : width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned digit);
    return $clog2(iter_count(width, digit) + 1);
  endfunction

  function automatic bit cfg_legal(input int unsigned width,
                                   input int unsigned digit);
    return (width >= 4) &&
           ((digit == 1) || (digit == 2) || (digit == 4)) &&
           ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/cla_nbits.sv
// N-bit carry-lookahead adder without carry-in; carry-out is not needed by the
// accumulate step because the partial sum is sized so it can never overflow.
module cla_nbits #(
  parameter int unsigned N = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic [N-2:0] g;
  logic [N-1:0] p;
  logic [N-1:0] carry;

  assign g = a[N-2:0] & b[N-2:0];
  assign p = a ^ b;

  // Each carry is the flattened sum-of-products of lower generates and propagates.
  always_comb begin
    logic term;
    logic c;
    carry = '0;
    term  = 1'b0;
    c     = 1'b0;
    for (int unsigned i = 1; i < N; i++) begin
      c = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c = c | term;
      end
      carry[i] = c;
    end
  end

  assign sum = p ^ carry;

endmodule

// File: rtl/multiplier_nbits_iterative.sv
// Multi-cycle signed/unsigned multiplier retiring DIGIT multiplier bits per
// clock, with valid/ready handshakes on both sides.
module multiplier_nbits_iterative
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned ITER  = iter_count(WIDTH, DIGIT);
  localparam int unsigned CNT_W = cnt_width(WIDTH, DIGIT);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + DIGIT;

  if (!cfg_legal(WIDTH, DIGIT)) begin : g_cfg_check
    $error("multiplier_nbits_iterative: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
  end

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              last_step;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  acc_hi;
  logic [WIDTH-1:0]  acc_lo;
  logic              neg;
  logic [CNT_W-1:0]  cnt;
  logic [SW-1:0]     addend;
  logic [SW-1:0]     partial;
  logic [SW-1:0]     step_sum;
  logic [PW-1:0]     step_acc;

  // -MIN maps onto 2^(WIDTH-1), which is representable as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // acc_lo doubles as the multiplier shift register: its low DIGIT bits are the
  // current digit and its vacated top bits collect the product's low half.
  assign addend  = {DIGIT'(0), acc_hi};
  assign partial = SW'(mag_a) * SW'(acc_lo[DIGIT-1:0]);

  cla_nbits #(
    .N (SW)
  ) u_cla (
    .a   (addend),
    .b   (partial),
    .sum (step_sum)
  );

  assign step_acc  = PW'({step_sum, acc_lo} >> DIGIT);
  assign last_step = (state == CALC) && (cnt == CNT_W'(ITER - 1));
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready follows out_ready in DONE so a new pair can issue on the handshake cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mag_a  <= magnitude(a, signed_mode);
      acc_lo <= magnitude(b, signed_mode);
      acc_hi <= '0;
      cnt    <= '0;
      neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == CALC) begin
      acc_hi <= step_acc[PW-1:WIDTH];
      acc_lo <= step_acc[WIDTH-1:0];
      cnt    <= cnt + CNT_W'(1);
      if (last_step) begin
        product <= neg ? (~step_acc + PW'(1)) : step_acc;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_nbits_iterative.sv
// Directed plus randomized bench for the iterative multiplier across several
// WIDTH/DIGIT configurations, checked against an integer-arithmetic model.
module tb_multiplier_nbits_iterative;

  logic clk;
  logic rst;

  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        in_valid4, sm4, out_ready4;
  logic [3:0]  a4, b4;
  logic [2:0]  in_ready4, out_valid4, busy4;
  logic [7:0]  product4 [3];

  logic        in_valid16, in_ready16, sm16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pa [3] = '{8'd3, 8'd7, 8'd12};
  logic [7:0] pb [3] = '{8'd5, 8'd9, 8'd12};

  multiplier_nbits_iterative #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  for (genvar k = 0; k < 3; k++) begin : g_w4
    multiplier_nbits_iterative #(.WIDTH(4), .DIGIT(1 << k)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4[k]),
      .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4[k]),
      .out_ready(out_ready4), .product(product4[k]), .busy(busy4[k])
    );
  end

  multiplier_nbits_iterative #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_mode(sm16), .out_valid(out_valid16),
    .out_ready(out_ready16), .product(product16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: interpret operands as integers and multiply.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s);
    longint xv, yv, p, mask;
    xv = longint'(x);
    yv = longint'(y);
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    p    = xv * yv;
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'(p & mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation on the 8-bit instance; called at a falling edge.
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input string tag);
    int k;
    logic [31:0] exp;
    exp = ref_mul(8, 16'(x), 16'(y), s);
    a8 = x; b8 = y; sm8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    k = 1;
    while (!out_valid8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'd5);
    check({tag, "_prod"}, 32'(product8), exp);
    @(negedge clk);
    check({tag, "_idle"}, 32'(out_valid8), 32'd0);
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input string tag);
    int k;
    logic [31:0] exp;
    exp = ref_mul(16, x, y, s);
    a16 = x; b16 = y; sm16 = s; in_valid16 = 1'b1; out_ready16 = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(in_ready16), 32'd1);
    @(negedge clk);
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    check({tag, "_busy"}, 32'(busy16), 32'd1);
    k = 1;
    while (!out_valid16 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'd5);
    check({tag, "_prod"}, product16, exp);
    @(negedge clk);
  endtask

  initial begin
    int          k;
    int          got_lat [3];
    logic [31:0] got_prod [3];
    logic [31:0] exp;
    logic [7:0]  hold_a, hold_b;
    logic        stale;

    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; out_ready16 = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready8), 32'd0);
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_product", 32'(product8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);

    // Directed extremes
    do_op8(8'hFF, 8'hFF, 1'b0, "u_max");
    do_op8(8'h80, 8'h80, 1'b1, "s_min_min");
    do_op8(8'h80, 8'h7F, 1'b1, "s_min_max");
    do_op8(8'h00, 8'hFB, 1'b1, "s_zero_neg");
    do_op8(8'hFF, 8'h01, 1'b1, "s_m1_p1");

    // Backpressure: result held while out_ready low, in_valid pulses ignored
    hold_a = 8'h12; hold_b = 8'h34;
    exp = ref_mul(8, 16'(hold_a), 16'(hold_b), 1'b0);
    a8 = hold_a; b8 = hold_b; sm8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    k = 1;
    while (!out_valid8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_lat", 32'(k), 32'd5);
    for (int c = 0; c < 10; c++) begin
      in_valid8 = 1'(c); a8 = 8'($urandom); b8 = 8'($urandom);
      #1;
      check("bp_out_valid", 32'(out_valid8), 32'd1);
      check("bp_product", 32'(product8), exp);
      check("bp_in_ready", 32'(in_ready8), 32'd0);
      @(negedge clk);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    #1 check("bp_release_in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    check("bp_handshake_drop", 32'(out_valid8), 32'd0);
    check("bp_product_hold", 32'(product8), exp);
    check("bp_busy_idle", 32'(busy8), 32'd0);
    @(negedge clk);
    check("bp_single_handshake", 32'(out_valid8), 32'd0);

    // Back-to-back issue with no idle cycle between results
    a8 = pa[0]; b8 = pb[0]; sm8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    for (int idx = 0; idx < 3; idx++) begin
      @(negedge clk);
      k = 1;
      check("b2b_busy", 32'(busy8), 32'd1);
      if (idx < 2) begin
        a8 = pa[idx+1]; b8 = pb[idx+1];
      end else begin
        in_valid8 = 1'b0;
      end
      while (!out_valid8 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("b2b_lat", 32'(k), 32'd5);
      check("b2b_prod", 32'(product8), ref_mul(8, 16'(pa[idx]), 16'(pb[idx]), 1'b0));
      check("b2b_in_ready", 32'(in_ready8), 32'd1);
    end
    @(negedge clk);
    check("b2b_end_valid", 32'(out_valid8), 32'd0);
    check("b2b_end_busy", 32'(busy8), 32'd0);

    // Reset two cycles after accept discards the in-flight result
    a8 = 8'h55; b8 = 8'h66; sm8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid8), 32'd0);
    check("midrst_in_ready", 32'(in_ready8), 32'd1);
    check("midrst_busy", 32'(busy8), 32'd0);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      stale = stale | out_valid8;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    do_op8(8'd6, 8'd7, 1'b0, "post_rst_6x7");

    // Randomized operations with gaps; operands scrambled during CALC
    for (int i = 0; i < 30; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // 4-bit exhaustive sweep on DIGIT = 1, 2, 4 instances in parallel
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a4 = 4'(x); b4 = 4'(y); sm4 = 1'(s); in_valid4 = 1'b1;
          exp = ref_mul(4, 16'(x), 16'(y), 1'(s));
          for (int i = 0; i < 3; i++) begin
            got_lat[i] = 0;
            got_prod[i] = '0;
          end
          #1 check("w4_in_ready", 32'(in_ready4), 32'd7);
          @(negedge clk);
          in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
          check("w4_busy", 32'(busy4), 32'd7);
          for (int kk = 1; kk <= 6; kk++) begin
            for (int i = 0; i < 3; i++) begin
              if (out_valid4[i] && got_lat[i] == 0) begin
                got_lat[i]  = kk;
                got_prod[i] = 32'(product4[i]);
              end
            end
            @(negedge clk);
          end
          for (int i = 0; i < 3; i++) begin
            check($sformatf("w4_d%0d_lat a=%0d b=%0d s=%0d", 1 << i, x, y, s),
                  32'(got_lat[i]), 32'((4 >> i) + 1));
            check($sformatf("w4_d%0d_prod a=%0d b=%0d s=%0d", 1 << i, x, y, s),
                  got_prod[i], exp);
          end
        end
      end
    end

    // 16-bit, DIGIT=4 instance
    do_op16(16'h8000, 16'h8000, 1'b1, "w16_min_min");
    do_op16(16'hFFFF, 16'hFFFF, 1'b0, "w16_umax");
    for (int i = 0; i < 20; i++) begin
      do_op16(16'($urandom), 16'($urandom), 1'($urandom), "w16_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multiplier_nbits_iterative.md
Name: multiplier_nbits_iterative

Overview:
Parametrised, multi-cycle successor to the 4-bit combinational multipliers. It multiplies two WIDTH-bit operands, signed or unsigned, retiring DIGIT multiplier bits per clock using a shift-add datapath. A parametrised carry-lookahead adder forms each partial-sum step. Valid/ready handshakes on input and output let it sit between streaming stages, with backpressure and back-to-back issue.

Parameters:
WIDTH, 8, operand width in bits; >=4; WIDTH % DIGIT == 0.
DIGIT, 2, multiplier bits retired per cycle; legal values 1, 2, 4.
ITER, WIDTH/DIGIT (derived localparam), number of compute cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair presented.
in_ready  output  1  block accepts an operand pair this cycle.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = two's-complement operands; sampled with a/b.
out_valid  output  1  product available.
out_ready  input  1  consumer takes the product this cycle.
product  output  2*WIDTH  result; two's complement when signed_mode was 1.
busy  output  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: state=IDLE, out_valid=0, product=0, busy=0, in_ready=0 during the reset cycle, then 1. Internal registers (accumulator, counter, magnitudes, sign) clear to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture |a| and |b| as WIDTH-bit unsigned magnitudes. When signed_mode=1, take two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  - Capture neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear accumulator and counter, then go to CALC.
- CALC:
  - Each cycle: acc = acc + (mag_a * mag_b[DIGIT-1:0]) << (WIDTH); then acc shifts right DIGIT bits and mag_b shifts right DIGIT bits.
  - The equivalent left-shift formulation is acceptable if results match bit-for-bit.
  - Counter increments each cycle; after ITER cycles, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1.
  - product = neg ? -acc : acc, truncated to 2*WIDTH bits, registered on entry to DONE.
  - product and out_valid stay stable until out_ready=1.
  - On out_valid & out_ready: if in_valid is also high, accept the new operands in the same cycle and go directly to CALC. Otherwise go to IDLE.
  - in_ready = out_ready while in DONE. This is the only combinational path from input to output.
- Latency: operands accepted at cycle T give out_valid at T+ITER+1 (WIDTH=8, DIGIT=2: T+5).
- Throughput: with out_ready held high, one result every ITER+1 cycles.
- Zero-result sign: a zero result with neg=1 yields 0; negative zero is not possible.
- Operand capture: a, b and signed_mode are ignored except in accept cycles. Changing them mid-CALC has no effect.
- Reset mid-operation: the in-flight result is discarded and out_valid drops on the next edge. No stale product appears after reset.
- Output hold: product holds its last value after handshake until the next DONE entry. Its value is not meaningful when out_valid=0.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, CALC, DONE};
  - localparam functions for ITER and counter width ($clog2(ITER+1));
  - a legality check on the WIDTH/DIGIT combination, with an elaboration error on violation.
- Sub-module cla_nbits #(N):
  - parametrised generate/propagate carry-lookahead adder, no carry-in, N = WIDTH+DIGIT;
  - generalises the fixed 7-bit CLA;
  - one instance for the accumulate step.
  - The final negation uses a plain inverted-plus-one expression.

Test Plan:
- Unsigned max: WIDTH=8, DIGIT=2, a=0xFF, b=0xFF, signed_mode=0 -> product=0xFE01, out_valid exactly 5 cycles after accept.
- Signed extremes: a=0x80, b=0x80, signed_mode=1 -> 0x4000; a=0x80, b=0x7F -> 0xC080; a=0x00, b=0xFB -> 0x0000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> product/out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> a single handshake.
- Back-to-back: out_ready=1 and in_valid=1 continuously with pairs (3,5), (7,9), (12,12) -> products 15, 63, 144 issued every 5 cycles, with no IDLE cycle between.
- Reset mid-CALC: assert rst 2 cycles after accept -> out_valid=0 and in_ready=1 the cycle after rst deasserts. The next op (6*7) returns 42.
- Exhaustive/random sweep: WIDTH=4 with DIGIT=1,2,4, all 256 pairs in both modes, compared against a behavioural a*b model. Include a DIGIT=4 elaboration check at WIDTH=16.
